moving_sum_decoder: RTL and testbench

- Inverse of the team's power-of-two moving-average stage: it rebuilds the original sample stream x(n) from a stream of full-precision window sums S(n) = SUM over k=0..N-1 of x(n-k), where N = 2^WIND_WIDTH.
- Samples before the first input count as zero.
- Sits on the verification/loopback path behind the averager's accumulator tap. It is also used in links that carry window sums instead of raw samples.
- Recursion: x(n) = S(n) - S(n-1) + x(n-N). This needs a depth-N history of reconstructed samples.

---
 rtl/moving_sum_decoder.sv | 98 +++++++++
 tb/tb_moving_sum_decoder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/moving_sum_decoder.sv
// moving_sum_decoder
//   Rebuilds a sample stream x(n) from a stream of full-precision window sums
//   S(n) = sum of the last N = 2^WIND_WIDTH samples, using
//   x(n) = S(n) - S(n-1) + x(n-N) with a depth-N history of decoded samples.
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   clear        synchronous restart (drops history, s_prev, fill count)
//   s_N          window sum S(n), unsigned, SUM_WIDTH bits
//   s_N_valid    s_N valid this cycle, one sum per asserted cycle
//   x_N          reconstructed sample, held between strobes
//   x_N_valid    one-cycle strobe, 1 clk after the accepted sum
//   window_full  high once N samples have been decoded since reset/clear
module moving_sum_decoder #(
  parameter  int WIND_WIDTH = 4,
  parameter  int DATA_WIDTH = 16,
  localparam int SUM_WIDTH  = DATA_WIDTH + WIND_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic [SUM_WIDTH-1:0]  s_N,
  input  logic                  s_N_valid,
  output logic [DATA_WIDTH-1:0] x_N,
  output logic                  x_N_valid,
  output logic                  window_full
);

  localparam int N = 1 << WIND_WIDTH;
  localparam logic [WIND_WIDTH:0] FILL_MAX  = (WIND_WIDTH+1)'(N);
  localparam logic [WIND_WIDTH:0] FILL_LAST = (WIND_WIDTH+1)'(N - 1);

  logic [DATA_WIDTH-1:0] r_hist [N];
  logic [SUM_WIDTH-1:0]  r_s_prev;
  logic [WIND_WIDTH-1:0] r_wr_ptr;
  logic [WIND_WIDTH:0]   r_fill_cnt;
  logic [DATA_WIDTH-1:0] r_x;
  logic                  r_x_valid;
  logic                  r_window_full;

  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_x_old;
  logic [SUM_WIDTH-1:0]  w_sum;
  logic [DATA_WIDTH-1:0] w_x_calc;

  assign w_accept = s_N_valid & ~clear;

  // Until the window has filled, the slot being overwritten holds stale data
  // from before reset/clear; those samples are defined to be zero.
  assign w_x_old  = r_window_full ? r_hist[r_wr_ptr] : '0;

  // Modular arithmetic: intermediate negative differences wrap and cancel.
  assign w_sum    = s_N - r_s_prev + SUM_WIDTH'(w_x_old);
  assign w_x_calc = w_sum[DATA_WIDTH-1:0];

  // History needs no reset: reads are masked until every slot is rewritten.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_hist[r_wr_ptr] <= w_x_calc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s_prev      <= '0;
      r_wr_ptr      <= '0;
      r_fill_cnt    <= '0;
      r_x           <= '0;
      r_x_valid     <= 1'b0;
      r_window_full <= 1'b0;
    end else if (clear) begin
      r_s_prev      <= '0;
      r_wr_ptr      <= '0;
      r_fill_cnt    <= '0;
      r_x_valid     <= 1'b0;
      r_window_full <= 1'b0;
    end else if (s_N_valid) begin
      r_s_prev  <= s_N;
      r_wr_ptr  <= r_wr_ptr + 1'b1;
      r_x       <= w_x_calc;
      r_x_valid <= 1'b1;
      if (r_fill_cnt != FILL_MAX) begin
        r_fill_cnt <= r_fill_cnt + 1'b1;
      end
      if (r_fill_cnt == FILL_LAST) begin
        r_window_full <= 1'b1;
      end
    end else begin
      r_x_valid <= 1'b0;
    end
  end

  assign x_N         = r_x;
  assign x_N_valid   = r_x_valid;
  assign window_full = r_window_full;

endmodule

// File: tb/tb_moving_sum_decoder.sv
module tb_moving_sum_decoder;

  // Small instance for directed vectors: N = 4, 8-bit samples, 10-bit sums.
  localparam int WW = 2;
  localparam int DW = 8;
  localparam int SW = DW + WW;

  // Large instance for the random regression: N = 16, 16-bit samples.
  localparam int RWW = 4;
  localparam int RDW = 16;
  localparam int RSW = RDW + RWW;
  localparam int RN  = 1 << RWW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear = 1'b0;
  logic [SW-1:0] s_N = '0;
  logic          s_N_valid = 1'b0;
  logic [DW-1:0] x_N;
  logic          x_N_valid;
  logic          window_full;

  logic           r_clear = 1'b0;
  logic [RSW-1:0] r_s = '0;
  logic           r_s_valid = 1'b0;
  logic [RDW-1:0] r_x;
  logic           r_x_valid;
  logic           r_wf;

  always #5 clk = ~clk;

  moving_sum_decoder #(.WIND_WIDTH(WW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .s_N(s_N), .s_N_valid(s_N_valid),
    .x_N(x_N), .x_N_valid(x_N_valid), .window_full(window_full)
  );

  moving_sum_decoder #(.WIND_WIDTH(RWW), .DATA_WIDTH(RDW)) dut_big (
    .clk(clk), .reset_n(reset_n), .clear(r_clear),
    .s_N(r_s), .s_N_valid(r_s_valid),
    .x_N(r_x), .x_N_valid(r_x_valid), .window_full(r_wf)
  );

  typedef struct {
    logic [SW-1:0] s;
    logic          v;
    logic          c;
    logic [DW-1:0] ex;
    logic          ev;
    logic          ewf;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic void add(input int s, input bit v, input bit c,
                              input int ex, input bit ev, input bit ewf);
    vec_t t;
    t.s = SW'(s); t.v = v; t.c = c; t.ex = DW'(ex); t.ev = ev; t.ewf = ewf;
    vecs.push_back(t);
  endfunction

  // Apply one cycle of input, then sample outputs just after the edge.
  task automatic step(input int s, input bit v, input bit c);
    @(negedge clk);
    s_N = SW'(s); s_N_valid = v; clear = c;
    @(posedge clk);
    #1;
    s_N_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic check_out(input string tag, input int ex, input bit ev, input bit ewf);
    chk({tag, ".x_N"}, 32'(x_N), 32'(ex));
    chk({tag, ".x_N_valid"}, 32'(x_N_valid), 32'(ev));
    chk({tag, ".window_full"}, 32'(window_full), 32'(ewf));
  endtask

  initial begin
    int fill_s [6];
    int fill_x [6];
    fill_s = '{10, 30, 60, 100, 140, 180};
    fill_x = '{10, 20, 30, 40, 50, 60};

    // Fill and steady state
    for (int i = 0; i < 6; i++) add(fill_s[i], 1, 0, fill_x[i], 1, i >= 3);
    // clear alone: x_N holds, strobe and window_full drop
    add(0, 0, 1, 60, 0, 0);
    // Wrap arithmetic with constant 255, then 255, 0
    add(255, 1, 0, 255, 1, 0);
    add(510, 1, 0, 255, 1, 0);
    add(765, 1, 0, 255, 1, 0);
    add(1020, 1, 0, 255, 1, 1);
    add(1020, 1, 0, 255, 1, 1);
    add(1020, 1, 0, 255, 1, 1);
    add(1020, 1, 0, 255, 1, 1);
    add(765, 1, 0, 0, 1, 1);
    add(0, 0, 1, 0, 0, 0);
    // Valid gaps: same stream as the fill test with 0-3 idle cycles
    add(10, 1, 0, 10, 1, 0);
    add(999, 0, 0, 10, 0, 0);
    add(30, 1, 0, 20, 1, 0);
    add(999, 0, 0, 20, 0, 0);
    add(999, 0, 0, 20, 0, 0);
    add(60, 1, 0, 30, 1, 0);
    add(999, 0, 0, 30, 0, 0);
    add(999, 0, 0, 30, 0, 0);
    add(999, 0, 0, 30, 0, 0);
    add(100, 1, 0, 40, 1, 1);
    add(140, 1, 0, 50, 1, 1);
    add(999, 0, 0, 50, 0, 1);
    add(180, 1, 0, 60, 1, 1);
    // clear mid-stream, simultaneous with a valid sum that must be dropped
    add(0, 0, 1, 60, 0, 0);
    add(10, 1, 0, 10, 1, 0);
    add(30, 1, 0, 20, 1, 0);
    add(60, 1, 0, 30, 1, 0);
    add(100, 1, 1, 30, 0, 0);
    add(7, 1, 0, 7, 1, 0);
    add(12, 1, 0, 5, 1, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      step(int'(vecs[i].s), vecs[i].v, vecs[i].c);
      check_out($sformatf("vec%0d", i), int'(vecs[i].ex), vecs[i].ev, vecs[i].ewf);
    end

    // Async reset mid-stream: assert between edges, no clock edge in between
    step(0, 0, 1);
    for (int i = 0; i < 3; i++) step(fill_s[i], 1, 0);
    check_out("pre_rst", 30, 1, 0);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_out("async_rst", 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(fill_s[i], 1, 0);
      check_out($sformatf("restart%0d", i), fill_x[i], 1, i >= 3);
    end

    // Random regression on the large instance with an encoder model
    begin
      logic [RDW-1:0] win [RN];
      logic [RSW-1:0] gsum;
      logic [RDW-1:0] xv;
      int             wp;
      int             errs;
      int             strobes;
      gsum = '0; wp = 0; errs = 0; strobes = 0;
      for (int k = 0; k < RN; k++) win[k] = '0;
      for (int n = 0; n < 10000; n++) begin
        while ($urandom_range(0, 3) == 0) begin
          @(negedge clk);
          r_s_valid = 1'b0;
          @(posedge clk);
          #1;
          if (r_x_valid !== 1'b0) errs++;
        end
        xv   = RDW'($urandom);
        gsum = gsum + RSW'(xv) - RSW'(win[wp]);
        win[wp] = xv;
        wp = (wp + 1) % RN;
        @(negedge clk);
        r_s = gsum; r_s_valid = 1'b1;
        @(posedge clk);
        #1;
        r_s_valid = 1'b0;
        if (r_x_valid === 1'b1) strobes++;
        if (r_x !== xv || r_x_valid !== 1'b1) begin
          errs++;
          if (errs < 5) $display("FAIL random[%0d]: got %0d expected %0d", n, r_x, xv);
        end
      end
      chk("random.errors", 32'(errs), 32'd0);
      chk("random.strobes", 32'(strobes), 32'd10000);
      chk("random.window_full", 32'(r_wf), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
